// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync monitor: recovers h/v position from hSync/vSync and checks timing.
// Optional violation counter enabled by defining VSM_ERR_COUNT_EN (otherwise err_count is tied to 0).
module vga_sync_monitor #(
  parameter int unsigned CLKS_PER_PIX = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned H_TOL        = 4,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hSync,
  input  logic       vSync,
  output logic       locked,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       frame_tick,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);

  localparam int unsigned HCLK_W    = 12;
  localparam int unsigned PW        = HCLK_W + 1;
  localparam int unsigned POS_W     = 10;
  localparam int unsigned EC_W      = 8;
  localparam int unsigned PIX_SHIFT = $clog2(CLKS_PER_PIX);
  localparam int unsigned GOOD_W    = $clog2(LOCK_FRAMES + 1);

  localparam logic [PW-1:0] H_PER_LO = PW'(H_TOTAL * CLKS_PER_PIX - H_TOL);
  localparam logic [PW-1:0] H_PER_HI = PW'(H_TOTAL * CLKS_PER_PIX + H_TOL);
  localparam logic [PW-1:0] H_LOW_LO = PW'(H_SYNC * CLKS_PER_PIX - H_TOL);
  localparam logic [PW-1:0] H_LOW_HI = PW'(H_SYNC * CLKS_PER_PIX + H_TOL);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic              hs_meta_q, hs_sync_q, hs_hist_q;
  logic              vs_meta_q, vs_sync_q, vs_hist_q;
  logic              hs_fall, hs_rise, vs_fall, vs_rise;
  logic [HCLK_W-1:0] hclk_q, hclk_d;
  logic [PW-1:0]     hclk_p1;
  logic              to_hold_q, to_hold_d;
  logic              h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic [POS_W-1:0]  line_cnt_q, line_cnt_d, lines_end;
  logic [POS_W-1:0]  vlow_q, vlow_d;
  logic [POS_W-1:0]  h_pos_q, h_pos_d;
  logic              h_viol, v_viol, any_viol;
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              dirty_q, dirty_d;
  logic              locked_q, locked_d;
  logic              frame_tick_q, frame_tick_d;
  logic              h_err_q, h_err_d, v_err_q, v_err_d;

  // Edge detect on the synchronized level vs. its one-cycle history
  assign hs_fall = !hs_sync_q &&  hs_hist_q;
  assign hs_rise =  hs_sync_q && !hs_hist_q;
  assign vs_fall = !vs_sync_q &&  vs_hist_q;
  assign vs_rise =  vs_sync_q && !vs_hist_q;

  // Position recovery and sync-period checks
  always_comb begin
    hclk_p1   = {1'b0, hclk_q} + PW'(1);
    lines_end = line_cnt_q + POS_W'(hs_fall);
    h_viol    = 1'b0;
    v_viol    = 1'b0;
    hclk_d    = hclk_q;
    to_hold_d = to_hold_q;
    vlow_d    = vlow_q;

    if (h_armed_q) begin
      if (hs_fall && (hclk_p1 < H_PER_LO || hclk_p1 > H_PER_HI)) h_viol = 1'b1;
      if (hs_rise && (hclk_p1 < H_LOW_LO || hclk_p1 > H_LOW_HI)) h_viol = 1'b1;
      if (hclk_q == '1 && !to_hold_q) h_viol = 1'b1;
    end
    if (v_armed_q) begin
      if (vs_fall && lines_end != POS_W'(V_TOTAL)) v_viol = 1'b1;
      if (vs_rise && vlow_q != POS_W'(V_SYNC))     v_viol = 1'b1;
    end

    if (hs_fall)             hclk_d = '0;
    else if (hclk_q != '1)   hclk_d = hclk_q + HCLK_W'(1);

    // Timeout reports once per stalled line
    if (hs_fall)                          to_hold_d = 1'b0;
    else if (h_armed_q && hclk_q == '1)   to_hold_d = 1'b1;

    if (vs_fall)                   vlow_d = POS_W'(hs_fall);
    else if (hs_fall && !vs_sync_q) vlow_d = vlow_q + POS_W'(1);

    line_cnt_d = vs_fall ? '0 : lines_end;
    h_armed_d  = h_armed_q | hs_fall;
    v_armed_d  = v_armed_q | vs_fall;
    h_pos_d    = POS_W'(hclk_d >> PIX_SHIFT);
    any_viol   = h_viol | v_viol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_meta_q  <= 1'b1;
      hs_sync_q  <= 1'b1;
      hs_hist_q  <= 1'b1;
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      vs_hist_q  <= 1'b1;
      hclk_q     <= '0;
      to_hold_q  <= 1'b0;
      h_armed_q  <= 1'b0;
      v_armed_q  <= 1'b0;
      line_cnt_q <= '0;
      vlow_q     <= '0;
      h_pos_q    <= '0;
    end else begin
      hs_meta_q  <= hSync;
      hs_sync_q  <= hs_meta_q;
      hs_hist_q  <= hs_sync_q;
      vs_meta_q  <= vSync;
      vs_sync_q  <= vs_meta_q;
      vs_hist_q  <= vs_sync_q;
      hclk_q     <= hclk_d;
      to_hold_q  <= to_hold_d;
      h_armed_q  <= h_armed_d;
      v_armed_q  <= v_armed_d;
      line_cnt_q <= line_cnt_d;
      vlow_q     <= vlow_d;
      h_pos_q    <= h_pos_d;
    end
  end

  // Lock FSM: next state, good-frame tracking and event outputs
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    dirty_d      = dirty_q;
    frame_tick_d = vs_fall;
    h_err_d      = h_viol && (state_q != ST_SEARCH);
    v_err_d      = v_viol && (state_q != ST_SEARCH);
    locked_d     = (state_q == ST_LOCKED);

    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
          dirty_d = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (any_viol) begin
          good_d  = '0;
          dirty_d = !vs_fall;
        end else if (vs_fall) begin
          dirty_d = 1'b0;
          if (dirty_q) begin
            good_d = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
            if (good_q + GOOD_W'(1) == GOOD_W'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (any_viol) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SEARCH;
      good_q       <= '0;
      dirty_q      <= 1'b0;
      locked_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      dirty_q      <= dirty_d;
      locked_q     <= locked_d;
      frame_tick_q <= frame_tick_d;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
    end
  end

`ifdef VSM_ERR_COUNT_EN
  logic [EC_W-1:0] err_cnt_q;

  // Violations that break lock, saturating; h and v in one cycle count once
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (state_q == ST_LOCKED && any_viol && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + EC_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign locked     = locked_q;
  assign h_pos      = h_pos_q;
  assign v_pos      = line_cnt_q;
  assign frame_tick = frame_tick_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced 20x10 timing; a second instance with
// 2-line frames is used to reach err_count saturation within a short run.
module tb_vga_sync_monitor;

`ifdef VSM_ERR_COUNT_EN
  localparam int EC_ON = 1;
`else
  localparam int EC_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs  = 1'b1;
  logic       vs  = 1'b1;

  logic       locked, frame_tick, h_err, v_err;
  logic [9:0] h_pos, v_pos;
  logic [7:0] err_count;

  logic       s_locked, s_frame_tick, s_h_err, s_v_err;
  logic [9:0] s_h_pos, s_v_pos;
  logic [7:0] s_err_count;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .CLKS_PER_PIX(1), .H_TOTAL(20), .H_SYNC(3), .V_TOTAL(10), .V_SYNC(2), .H_TOL(0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hSync(hs), .vSync(vs), .locked(locked), .h_pos(h_pos), .v_pos(v_pos),
    .frame_tick(frame_tick), .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  vga_sync_monitor #(
    .CLKS_PER_PIX(1), .H_TOTAL(20), .H_SYNC(3), .V_TOTAL(2), .V_SYNC(1), .H_TOL(0), .LOCK_FRAMES(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .hSync(hs), .vSync(vs), .locked(s_locked), .h_pos(s_h_pos), .v_pos(s_v_pos),
    .frame_tick(s_frame_tick), .h_err(s_h_err), .v_err(s_v_err), .err_count(s_err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge
  int  cyc = 0;
  int  herr_cnt = 0, verr_cnt = 0, ft_cnt = 0;
  int  last_herr_cyc = -1, last_verr_cyc = -1, last_ft_cyc = -1;
  int  lock_rise_cyc = -1, lock_fall_cyc = -1;
  bit  prev_locked = 1'b0;
  int  s_rise_cnt = 0;
  bit  s_prev_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (h_err === 1'b1)      begin herr_cnt++; last_herr_cyc = cyc; end
    if (v_err === 1'b1)      begin verr_cnt++; last_verr_cyc = cyc; end
    if (frame_tick === 1'b1) begin ft_cnt++;   last_ft_cyc   = cyc; end
    if (locked === 1'b1 && !prev_locked) lock_rise_cyc = cyc;
    if (locked === 1'b0 &&  prev_locked) lock_fall_cyc = cyc;
    prev_locked = (locked === 1'b1);
    if (s_locked === 1'b1 && !s_prev_locked) s_rise_cnt++;
    s_prev_locked = (s_locked === 1'b1);
  end

  // One line: hSync low for 3 clocks from clock 0; vSync may fall at clock 0 or rise at clock 10
  task automatic drive_line(input int len, input bit vfall, input bit vrise, input bit probe, input int exp_v);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (probe && c == 13) begin
        check_eq("h_pos_mid_line", 32'(h_pos), 32'd10);
        check_eq("v_pos_mid_frame", 32'(v_pos), 32'(exp_v));
      end
      if (c == 0 && vfall) vs = 1'b0;
      if (c == 10 && vrise) vs = 1'b1;
      hs = (c < 3) ? 1'b0 : 1'b1;
    end
  endtask

  // nl lines, vSync low across vl hSync falls, line sline lengthened to slen clocks
  task automatic drive_frame(input int nl, input int vl, input int sline, input int slen, input bit probe);
    for (int l = 0; l < nl; l++)
      drive_line((l == sline) ? slen : 20, l == 0, l == vl - 1, probe && l == 5, 5);
  endtask

  int hb, vb, sb;

  initial begin
    // Reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_h_pos", 32'(h_pos), 32'd0);
    check_eq("rst_v_pos", 32'(v_pos), 32'd0);
    check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
    check_eq("rst_h_err", 32'(h_err), 32'd0);
    check_eq("rst_v_err", 32'(v_err), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Clean timing: lock one cycle after the 3rd frame tick
    drive_frame(10, 2, -1, 20, 1'b0);
    drive_frame(10, 2, -1, 20, 1'b1);
    drive_frame(10, 2, -1, 20, 1'b0);
    check_eq("lock_after_3_falls", 32'(locked), 32'd1);
    check_eq("frame_ticks", 32'(ft_cnt), 32'd3);
    check_eq("lock_rise_timing", 32'(lock_rise_cyc), 32'(last_ft_cyc + 1));
    check_eq("clean_h_err", 32'(herr_cnt), 32'd0);
    check_eq("clean_v_err", 32'(verr_cnt), 32'd0);

    // Stretched line (21 clocks) while locked
    hb = herr_cnt; vb = verr_cnt;
    drive_frame(10, 2, 4, 21, 1'b0);
    check_eq("stretch_h_err", 32'(herr_cnt - hb), 32'd1);
    check_eq("stretch_v_err", 32'(verr_cnt - vb), 32'd0);
    check_eq("stretch_unlock_timing", 32'(lock_fall_cyc), 32'(last_herr_cyc + 1));
    check_eq("stretch_locked", 32'(locked), 32'd0);
    check_eq("stretch_err_count", 32'(err_count), 32'(EC_ON ? 1 : 0));
    repeat (3) drive_frame(10, 2, -1, 20, 1'b0);
    check_eq("stretch_relock", 32'(locked), 32'd1);

    // 11-line frame while locked: v_err at the following vSync fall
    hb = herr_cnt; vb = verr_cnt;
    drive_frame(11, 2, -1, 20, 1'b0);
    drive_frame(10, 2, -1, 20, 1'b0);
    check_eq("long_frame_v_err", 32'(verr_cnt - vb), 32'd1);
    check_eq("long_frame_h_err", 32'(herr_cnt - hb), 32'd0);
    check_eq("long_frame_err_at_tick", 32'(last_verr_cyc), 32'(last_ft_cyc));
    check_eq("long_frame_unlock_timing", 32'(lock_fall_cyc), 32'(last_verr_cyc + 1));
    check_eq("long_frame_err_count", 32'(err_count), 32'(EC_ON ? 2 : 0));
    repeat (3) drive_frame(10, 2, -1, 20, 1'b0);
    check_eq("long_frame_relock", 32'(locked), 32'd1);

    // vSync low across 3 lines: v_err at vSync rise
    hb = herr_cnt; vb = verr_cnt;
    drive_frame(10, 3, -1, 20, 1'b0);
    check_eq("vlow3_v_err", 32'(verr_cnt - vb), 32'd1);
    check_eq("vlow3_h_err", 32'(herr_cnt - hb), 32'd0);
    check_eq("vlow3_locked", 32'(locked), 32'd0);
    check_eq("vlow3_err_count", 32'(err_count), 32'(EC_ON ? 3 : 0));

    // hSync stalled high for 5000 clocks during ACQUIRE
    hb = herr_cnt;
    drive_line(20, 1'b1, 1'b0, 1'b0, 0);
    drive_line(20, 1'b0, 1'b1, 1'b0, 0);
    drive_line(20, 1'b0, 1'b0, 1'b0, 0);
    drive_line(5020, 1'b0, 1'b0, 1'b0, 0);
    check_eq("timeout_once", 32'(herr_cnt - hb), 32'd1);
    check_eq("timeout_h_pos_sat", 32'(h_pos), 32'd1023);
    for (int l = 4; l < 10; l++) drive_line(20, 1'b0, 1'b0, 1'b0, 0);
    check_eq("timeout_then_period_err", 32'(herr_cnt - hb), 32'd2);
    check_eq("timeout_err_count", 32'(err_count), 32'(EC_ON ? 3 : 0));
    check_eq("timeout_not_locked", 32'(locked), 32'd0);

    // Coincident hSync/vSync falls: clean 10-line frames must re-lock without errors
    hb = herr_cnt; vb = verr_cnt;
    repeat (3) drive_frame(10, 2, -1, 20, 1'b0);
    check_eq("coincident_relock", 32'(locked), 32'd1);
    check_eq("coincident_v_err", 32'(verr_cnt - vb), 32'd0);
    check_eq("coincident_h_err", 32'(herr_cnt - hb), 32'd0);

    // Saturation on the 2-line instance: 300 lock/error cycles
    repeat (4) drive_frame(2, 1, -1, 20, 1'b0);
    check_eq("sat_prologue_locked", 32'(s_locked), 32'd1);
    sb = s_rise_cnt;
    for (int i = 0; i < 300; i++) begin
      drive_frame(1, 1, -1, 20, 1'b0);
      drive_frame(1, 1, -1, 20, 1'b0);
      drive_frame(2, 1, -1, 20, 1'b0);
      drive_frame(2, 1, -1, 20, 1'b0);
      if (i == 9) check_eq("sat_err_count_10", 32'(s_err_count), 32'(EC_ON ? 10 : 0));
    end
    drive_frame(2, 1, -1, 20, 1'b0);
    check_eq("sat_relocks", 32'(s_rise_cnt - sb), 32'd300);
    check_eq("sat_locked_end", 32'(s_locked), 32'd1);
    check_eq("sat_err_count", 32'(s_err_count), 32'(EC_ON ? 255 : 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
